seg7_scan_reader: RTL and testbench
===================================

// Module: seg7_scan_reader
// PURPOSE
//   Reads back a time-multiplexed, active-low 7-segment display bus (anodes + segments) and recovers the BCD digit shown at each position.
//   Inverse of the BCD-to-segment decoder; used as a loop-back monitor on the display driver outputs and as a self-check for game-score display paths.
//   Captures only settled patterns, flags illegal patterns, and reports completed scan frames.
// PARAMETERS
//   N_DIGITS  4  number of multiplexed digit positions (anode width), 1..8
//   SETTLE    4  consecutive stable cycles required before capture, >=1
// PORTS
//   clk          in   1           system clock, rising edge
//   rst          in   1           asynchronous reset, active-high
//   an_n         in   N_DIGITS    anode enables, active-low; exactly one low = legal
//   seg_n        in   7           segments, active-low; bit0=a .. bit6=g
//   err_clr      in   1           clears sticky err
//   digits       out  4*N_DIGITS  recovered BCD; digit i at [4i+3:4i]
//   digit_valid  out  N_DIGITS    1 = digit i holds a legal capture
//   err          out  1           sticky: illegal segment pattern captured
//   frame_done   out  1           1-cycle pulse: every position captured since last pulse
// BEHAVIOUR
//   - Reset: digits=0, digit_valid=0, err=0, frame_done=0, seen-mask=0, stable counter=0, input register=all-ones.
//   - Input stage: {an_n,seg_n} are registered once into P.
//     - Counter cnt clears when P differs from its previous value; otherwise it increments, saturating at SETTLE.
//   - Capture fires on the single cycle where cnt goes SETTLE-1 -> SETTLE and P.an_n is legal (exactly one bit low).
//     - Outputs update on that edge: exactly SETTLE+2 rising edges after inputs become stable.
//     - At most one capture per stable interval; re-arm only after a change of P.
//   - Illegal anode (none low or >1 low): no capture, no error; cnt still runs.
//   - Decode table (seg_n hex, bit6..bit0) -> digit:
//     40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9
//   - Legal pattern at position i: digits[i]<=value, digit_valid[i]<=1.
//   - Pattern not in table: digits[i] unchanged, digit_valid[i]<=0, err<=1.
//   - err_clr clears err on the next edge. A new illegal capture in the same cycle wins: err stays 1.
//   - Every capture (legal or not) sets seen-mask bit i.
//     - When the mask would become all-ones, frame_done=1 for one cycle and the mask clears to 0 on the same edge.
//     - Re-capturing an already-seen position does not pulse frame_done.
//   - Pattern change during the settle window aborts that capture silently.
//   - Reset mid-frame discards all partial state.
//   - digits and digit_valid hold indefinitely if the bus stops scanning.
// CONFIGURATION
//   SEG7_READER_BLANK_EN
//     - Defined: seg_n=7F (all segments off) is legal. It captures as digits[i]=4'hF, digit_valid[i]=1, and does not set err.
//     - Undefined: 7F is an illegal pattern (digit_valid[i]<=0, err<=1), like any other unlisted code.
// TESTING
//   T1 reset: assert rst mid-run -> all outputs 0 immediately (asynchronous), mask cleared.
//   T2 an_n=1110, seg_n=24 held (SETTLE=4) -> at edge 6 digits[3:0]=2, digit_valid=0001, no earlier change.
//   T3 glitch: an_n=1101, seg_n=79 held 3 cycles, then changed -> digit 1 not updated, digit_valid unchanged.
//   T4 scan positions 0..3 with 79,10,40,78, each held 8 cycles -> digits=16'h7091, digit_valid=1111, exactly one frame_done pulse.
//   T5 an_n=1011, seg_n=7E -> digit_valid[2]=0, err=1.
//      Then err_clr alone -> err=0. err_clr coincident with new 7E capture -> err stays 1.
//   T6 an_n=1100 or 1111 held 20 cycles -> no capture, err=0.
//      seg_n=7F on legal anode: err=1 without the macro; digits[i]=F, valid=1 with SEG7_READER_BLANK_EN.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Loop-back reader for an active-low, time-multiplexed 7-segment bus: recovers the BCD digit per position.
// Optional feature macro: SEG7_READER_BLANK_EN (all-segments-off pattern captures as a legal 4'hF).
module seg7_scan_reader #(
    parameter int N_DIGITS = 4,
    parameter int SETTLE   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_DIGITS-1:0]     an_n,
    input  logic [6:0]              seg_n,
    input  logic                    err_clr,
    output logic [4*N_DIGITS-1:0]   digits,
    output logic [N_DIGITS-1:0]     digit_valid,
    output logic                    err,
    output logic                    frame_done
);

    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] C_MAX = CW'(SETTLE);
    localparam logic [CW-1:0] C_ARM = CW'(SETTLE - 1);

    logic [N_DIGITS-1:0]   r_an;
    logic [N_DIGITS-1:0]   r_an_d;
    logic [6:0]            r_seg;
    logic [6:0]            r_seg_d;
    logic [CW-1:0]         r_cnt;
    logic [4*N_DIGITS-1:0] r_digits;
    logic [N_DIGITS-1:0]   r_valid;
    logic [N_DIGITS-1:0]   r_seen;
    logic                  r_err;
    logic                  r_frame;

    logic                  w_stable;
    logic                  w_an_legal;
    logic                  w_cap;
    logic                  w_seg_ok;
    logic [3:0]            w_val;
    logic [N_DIGITS-1:0]   w_sel;
    logic [N_DIGITS-1:0]   w_seen_nx;

    assign w_sel      = ~r_an;
    assign w_stable   = (r_an == r_an_d) && (r_seg == r_seg_d);
    assign w_an_legal = $onehot(w_sel);
    // Fires only on the SETTLE-1 -> SETTLE step, so one capture per stable interval.
    assign w_cap      = w_stable && (r_cnt == C_ARM) && w_an_legal;
    assign w_seen_nx  = r_seen | w_sel;

    always_comb begin
        w_val    = '0;
        w_seg_ok = 1'b1;
        case (r_seg)
            7'h40:   w_val = 4'd0;
            7'h79:   w_val = 4'd1;
            7'h24:   w_val = 4'd2;
            7'h30:   w_val = 4'd3;
            7'h19:   w_val = 4'd4;
            7'h12:   w_val = 4'd5;
            7'h02:   w_val = 4'd6;
            7'h78:   w_val = 4'd7;
            7'h00:   w_val = 4'd8;
            7'h10:   w_val = 4'd9;
`ifdef SEG7_READER_BLANK_EN
            7'h7F:   w_val = 4'hF;
`endif
            default: w_seg_ok = 1'b0;
        endcase
    end

    // Stability is judged on the registered bus against its own previous sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an    <= '1;
            r_seg   <= '1;
            r_an_d  <= '1;
            r_seg_d <= '1;
            r_cnt   <= '0;
        end else begin
            r_an    <= an_n;
            r_seg   <= seg_n;
            r_an_d  <= r_an;
            r_seg_d <= r_seg;
            if (!w_stable)
                r_cnt <= '0;
            else if (r_cnt != C_MAX)
                r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= '0;
            r_valid  <= '0;
            r_seen   <= '0;
            r_err    <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_frame <= 1'b0;
            if (w_cap) begin
                for (int unsigned i = 0; i < N_DIGITS; i++) begin
                    if (w_sel[i]) begin
                        if (w_seg_ok) begin
                            r_digits[4*i +: 4] <= w_val;
                            r_valid[i]         <= 1'b1;
                        end else begin
                            r_valid[i]         <= 1'b0;
                        end
                    end
                end
                if (w_seen_nx == '1) begin
                    r_frame <= 1'b1;
                    r_seen  <= '0;
                end else begin
                    r_seen  <= w_seen_nx;
                end
            end
            if (w_cap && !w_seg_ok)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
        end
    end

    assign digits      = r_digits;
    assign digit_valid = r_valid;
    assign err         = r_err;
    assign frame_done  = r_frame;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Randomized and directed bench for seg7_scan_reader against a sample-history reference model.
// Honours SEG7_READER_BLANK_EN when defined for the build.
module tb_seg7_scan_reader;

    localparam int N = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   an_n;
    logic [6:0]     seg_n;
    logic           err_clr;
    logic [4*N-1:0] digits;
    logic [N-1:0]   digit_valid;
    logic           err;
    logic           frame_done;

    seg7_scan_reader #(.N_DIGITS(N), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .an_n(an_n), .seg_n(seg_n), .err_clr(err_clr),
        .digits(digits), .digit_valid(digit_valid), .err(err), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_frames = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a capture happens when the last sample has been seen exactly S+1 times in a row.
    logic [N-1:0] m_last_an;
    logic [6:0]   m_last_seg;
    int           m_run;
    logic [3:0]   m_dig [N];
    bit           m_val [N];
    bit           m_seen [N];
    bit           m_err;
    bit           m_frame;

    function automatic int decode(input logic [6:0] s);
        logic [6:0] codes [10];
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int i = 0; i < 10; i++)
            if (codes[i] == s) return i;
`ifdef SEG7_READER_BLANK_EN
        if (s == 7'h7F) return 15;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_last_an  = '1;
        m_last_seg = '1;
        m_run      = S + 2;
        m_err      = 0;
        m_frame    = 0;
        for (int i = 0; i < N; i++) begin
            m_dig[i]  = '0;
            m_val[i]  = 0;
            m_seen[i] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] a, input logic [6:0] s, input logic clr);
        bit err_set;
        bit all_seen;
        int pos;
        int d;
        err_set = 0;
        m_frame = 0;
        if (m_run == S + 1 && $countones(~m_last_an) == 1) begin
            pos = 0;
            for (int i = 0; i < N; i++)
                if (!m_last_an[i]) pos = i;
            d = decode(m_last_seg);
            if (d >= 0) begin
                m_dig[pos] = d[3:0];
                m_val[pos] = 1;
            end else begin
                m_val[pos] = 0;
                err_set    = 1;
            end
            m_seen[pos] = 1;
            all_seen = 1;
            for (int i = 0; i < N; i++)
                if (!m_seen[i]) all_seen = 0;
            if (all_seen) begin
                m_frame = 1;
                for (int i = 0; i < N; i++) m_seen[i] = 0;
            end
        end
        if (err_set)  m_err = 1;
        else if (clr) m_err = 0;
        if (a == m_last_an && s == m_last_seg) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_last_an  = a;
        m_last_seg = s;
    endtask

    function automatic logic [4*N-1:0] exp_digits();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = m_dig[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_valid();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_val[i];
        return v;
    endfunction

    task automatic compare_all();
        chk("digits", digits, exp_digits());
        chk("digit_valid", digit_valid, exp_valid());
        chk("err", err, m_err);
        chk("frame_done", frame_done, m_frame);
        if (frame_done === 1'b1) n_frames++;
    endtask

    task automatic cycle(input logic [N-1:0] a, input logic [6:0] s, input logic clr);
        @(negedge clk);
        an_n    = a;
        seg_n   = s;
        err_clr = clr;
        model_step(a, s, clr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [N-1:0] a, input logic [6:0] s, input int n);
        for (int k = 0; k < n; k++) cycle(a, s, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_digits", digits, 0);
        chk("rst_valid", digit_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_frame", frame_done, 0);
        an_n    = '1;
        seg_n   = '1;
        err_clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        model_step('1, '1, 1'b0);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [6:0]   rs;
        logic [6:0]   tbl [10];
        int           len;
        int           pick;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

        rst     = 1'b1;
        an_n    = '1;
        seg_n   = '1;
        err_clr = 1'b0;
        model_reset();
        #12;
        chk("init_digits", digits, 0);
        chk("init_valid", digit_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        model_step('1, '1, 1'b0);
        @(posedge clk);
        #1;
        compare_all();

        // Capture lands on the sixth edge of a stable hold
        for (int k = 1; k <= 8; k++) begin
            cycle(4'b1110, 7'h24, 1'b0);
            if (k == 5) chk("t2_valid_early", digit_valid, 4'b0000);
            if (k == 6) begin
                chk("t2_digit0", digits[3:0], 4'd2);
                chk("t2_valid", digit_valid, 4'b0001);
            end
        end

        // Glitch shorter than the settle window
        hold(4'b1101, 7'h79, 3);
        hold(4'b1101, 7'h24, 1);
        hold(4'b1111, 7'h79, 6);
        chk("t3_valid", digit_valid, 4'b0001);

        // Partial frame then asynchronous reset mid-run
        hold(4'b1011, 7'h30, 8);
        do_reset();

        n_frames = 0;
        hold(4'b1110, 7'h79, 8);
        hold(4'b1101, 7'h10, 8);
        hold(4'b1011, 7'h40, 8);
        hold(4'b0111, 7'h78, 8);
        chk("t4_digits", digits, 16'h7091);
        chk("t4_valid", digit_valid, 4'b1111);
        chk("t4_frames", n_frames, 1);

        // Illegal segment code, clear, and clear colliding with a new error
        hold(4'b1011, 7'h7E, 8);
        chk("t5_err_set", err, 1);
        cycle(4'b1111, 7'h7E, 1'b1);
        chk("t5_err_clr", err, 0);
        hold(4'b1111, 7'h40, 2);
        for (int k = 0; k < S + 2; k++)
            cycle(4'b1011, 7'h7E, (k == S + 1) ? 1'b1 : 1'b0);
        chk("t5_err_keep", err, 1);
        cycle(4'b1111, 7'h40, 1'b1);

        // Illegal anodes never capture; blank pattern depends on build option
        hold(4'b1100, 7'h40, 20);
        hold(4'b1111, 7'h24, 20);
        chk("t6_err", err, 0);
        hold(4'b0111, 7'h7F, 8);
`ifdef SEG7_READER_BLANK_EN
        chk("t6_blank_digit", digits[15:12], 4'hF);
        chk("t6_blank_valid", digit_valid[3], 1);
`else
        chk("t6_blank_err", err, 1);
        chk("t6_blank_valid", digit_valid[3], 0);
`endif

        for (int seq = 0; seq < 300; seq++) begin
            pick = $urandom_range(0, 99);
            if (pick < 80)      rs = tbl[$urandom_range(0, 9)];
            else if (pick < 90) rs = 7'h7F;
            else                rs = 7'($urandom);
            if ($urandom_range(0, 99) < 85) begin
                ra = '1;
                ra[$urandom_range(0, N-1)] = 1'b0;
            end else begin
                ra = N'($urandom);
            end
            len = $urandom_range(1, 10);
            for (int k = 0; k < len; k++)
                cycle(ra, rs, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
            if (seq == 150) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
